udb_cascade_counter: RTL and testbench
======================================

// Module: udb_cascade_counter
//
// PURPOSE
//   Parametrised multi-digit up/down counter with synchronous parallel load, count enable,
//   wrap flag and load-range checking. Each digit counts in radix MODULUS. Digits ripple
//   carry/borrow within a single clock cycle.
//   Drives multi-digit 7-segment display paths. Replaces the single-digit up/down counter
//   in the board-level counter/shifter designs.
//
// PARAMETERS
//   DIGITS   4   number of cascaded digits, 1..8
//   MODULUS  10  per-digit radix, 2..16 (10 = BCD)
//   DIGIT_W  4   bits per digit; must satisfy 2**DIGIT_W >= MODULUS
//
// PORTS
//   udbManager_clk         in   1               clock; all state changes on posedge
//   udbManager_rst         in   1               reset, asynchronous, active-high
//   udbManager_en          in   1               count enable
//   udbManager_load        in   1               synchronous load strobe
//   udbManager_load_value  in   DIGITS*DIGIT_W  load data; digit 0 = LSBs
//   udbManager_direction   in   1               1 = up, 0 = down
//   udbManager_count       out  DIGITS*DIGIT_W  registered count; digit 0 = LSBs
//   udbManager_wrap        out  1               one-cycle pulse on full-range wrap
//   udbManager_load_err    out  1               one-cycle pulse when load data is out of range
//
// BEHAVIOUR
// - Reset: the counter uses asynchronous, active-high reset udbManager_rst and clock
//   udbManager_clk. Asserting reset immediately clears count, wrap and load_err to 0,
//   including mid-count. The first active edge after reset release is treated as normal.
// - Priority at each posedge: load > count (en=1) > hold (en=0).
//   load=1 ignores en and direction.
// - Load: each digit takes its load_value field. A field >= MODULUS is clamped to
//   MODULUS-1, and load_err is 1 for that cycle. Otherwise load_err is 0.
//   wrap is 0 on a load cycle.
// - Count up: digit 0 increments. Digit i steps when every lower digit == MODULUS-1.
//   A stepping digit at MODULUS-1 goes to 0.
// - Count down: digit 0 decrements. Digit i steps when every lower digit == 0.
//   A stepping digit at 0 goes to MODULUS-1.
// - wrap: 1 in the cycle following an edge that moved the count between all-(MODULUS-1)
//   and all-0, in either direction. Otherwise 0.
// - Latency: all outputs are registered. A new value is visible 1 cycle after the sampling
//   edge. There is no combinational path from inputs to outputs.
// - Direction may change on any cycle. The new direction takes effect on the same edge.
// - Illegal digit values cannot arise internally. Load clamping guarantees every digit
//   is < MODULUS.
//
// CONFIGURATION
//   UDB_SATURATE_EN defined:
//     - Up count at all-(MODULUS-1) holds the value; down count at all-0 holds the value.
//     - In those cases wrap stays 0 and is tied low.
//   UDB_SATURATE_EN undefined: wrap-around as described above (default).
//
// TESTING  (DIGITS=2, MODULUS=10 unless noted)
// - rst=1 while counting at 0x47 -> count=0x00 immediately, before the next edge;
//   wrap=0, load_err=0.
// - load 0x98, then en=1, dir=1 for 2 clocks -> count 0x99, then 0x00;
//   wrap=1 for exactly 1 cycle after the second edge.
// - load 0x00, en=1, dir=0 for 1 clock -> count=0x99 and wrap=1.
//   Then load 0x10, dir=0 -> count=0x09 (borrow ripple), wrap=0.
// - load 0x3C -> count=0x39 and load_err=1 for 1 cycle.
//   With en=0 for 5 clocks afterwards, count stays 0x39.
// - load=1 and en=1 in the same cycle, load_value=0x25 -> count=0x25 (load wins).
// - UDB_SATURATE_EN build: load 0x99, up x3 -> count stays 0x99, wrap=0.
//   Load 0x00, down x3 -> count stays 0x00.

Source files
------------

// File: rtl/udb_cascade_counter.sv
// udb_cascade_counter: multi-digit up/down counter, radix MODULUS per digit, with
// synchronous clamped parallel load, count enable, full-range wrap pulse and load
// range-error pulse. Carry/borrow ripples through all digits in one cycle.
// Build option: define UDB_SATURATE_EN to hold at the full-range endpoints instead of
// wrapping (wrap is then never asserted).
module udb_cascade_counter #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MODULUS = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                      udbManager_clk,
  input  logic                      udbManager_rst,
  input  logic                      udbManager_en,
  input  logic                      udbManager_load,
  input  logic [DIGITS*DIGIT_W-1:0] udbManager_load_value,
  input  logic                      udbManager_direction,
  output logic [DIGITS*DIGIT_W-1:0] udbManager_count,
  output logic                      udbManager_wrap,
  output logic                      udbManager_load_err
);

  localparam int unsigned CountW = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MaxDigit = DIGIT_W'(MODULUS - 1);

  logic [CountW-1:0] countQ, countD;
  logic              wrapQ, wrapD;
  logic              loadErrQ, loadErrD;
  logic              allMax, allZero;

  // Detect the two full-range endpoints (all digits at MODULUS-1, all digits at 0)
  always_comb begin
    allMax  = 1'b1;
    allZero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (countQ[i*DIGIT_W +: DIGIT_W] != MaxDigit) allMax = 1'b0;
      if (countQ[i*DIGIT_W +: DIGIT_W] != '0) allZero = 1'b0;
    end
  end

  // Next-state: load (with clamping) beats count, count beats hold
  always_comb begin
    logic [DIGIT_W-1:0] digit;
    logic               carry;
    countD   = countQ;
    wrapD    = 1'b0;
    loadErrD = 1'b0;
    digit    = '0;
    carry    = 1'b0;
    if (udbManager_load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit = udbManager_load_value[i*DIGIT_W +: DIGIT_W];
        if (digit > MaxDigit) begin
          digit    = MaxDigit;
          loadErrD = 1'b1;
        end
        countD[i*DIGIT_W +: DIGIT_W] = digit;
      end
    end else if (udbManager_en) begin
      if (udbManager_direction) begin
`ifdef UDB_SATURATE_EN
        carry = !allMax;
`else
        carry = 1'b1;
        wrapD = allMax;
`endif
        // carry stays set only while the lower digits were all at MaxDigit
        for (int unsigned i = 0; i < DIGITS; i++) begin
          digit = countQ[i*DIGIT_W +: DIGIT_W];
          if (carry) begin
            if (digit == MaxDigit) begin
              digit = '0;
            end else begin
              digit = digit + DIGIT_W'(1);
              carry = 1'b0;
            end
          end
          countD[i*DIGIT_W +: DIGIT_W] = digit;
        end
      end else begin
`ifdef UDB_SATURATE_EN
        carry = !allZero;
`else
        carry = 1'b1;
        wrapD = allZero;
`endif
        // borrow stays set only while the lower digits were all at 0
        for (int unsigned i = 0; i < DIGITS; i++) begin
          digit = countQ[i*DIGIT_W +: DIGIT_W];
          if (carry) begin
            if (digit == '0) begin
              digit = MaxDigit;
            end else begin
              digit = digit - DIGIT_W'(1);
              carry = 1'b0;
            end
          end
          countD[i*DIGIT_W +: DIGIT_W] = digit;
        end
      end
    end
  end

  // State registers with asynchronous active-high clear
  always_ff @(posedge udbManager_clk or posedge udbManager_rst) begin
    if (udbManager_rst) begin
      countQ   <= '0;
      wrapQ    <= 1'b0;
      loadErrQ <= 1'b0;
    end else begin
      countQ   <= countD;
      wrapQ    <= wrapD;
      loadErrQ <= loadErrD;
    end
  end

  assign udbManager_count    = countQ;
  assign udbManager_wrap     = wrapQ;
  assign udbManager_load_err = loadErrQ;

endmodule

// File: tb/tb_udb_cascade_counter.sv
// Self-checking bench for udb_cascade_counter (DIGITS=2, MODULUS=10).
// The reference model keeps the count as a plain integer 0..99 and converts to BCD.
// Honours UDB_SATURATE_EN when defined.
module tb_udb_cascade_counter;

  localparam int unsigned DIGITS  = 2;
  localparam int unsigned MODULUS = 10;
  localparam int unsigned DIGIT_W = 4;
  localparam int          TopVal  = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic       dir;
  logic [7:0] loadValue;
  logic [7:0] count;
  logic       wrap;
  logic       loadErr;

  int vecCount  = 0;
  int missCount = 0;
  int modelVal  = 0;
  bit modelWrap = 1'b0;
  bit modelErr  = 1'b0;

  udb_cascade_counter #(
    .DIGITS (DIGITS),
    .MODULUS(MODULUS),
    .DIGIT_W(DIGIT_W)
  ) dut (
    .udbManager_clk       (clk),
    .udbManager_rst       (rst),
    .udbManager_en        (en),
    .udbManager_load      (load),
    .udbManager_load_value(loadValue),
    .udbManager_direction (dir),
    .udbManager_count     (count),
    .udbManager_wrap      (wrap),
    .udbManager_load_err  (loadErr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(bit ld, bit e, bit d, logic [7:0] lv);
    int hi;
    int lo;
    modelWrap = 1'b0;
    modelErr  = 1'b0;
    if (ld) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > 9) begin hi = 9; modelErr = 1'b1; end
      if (lo > 9) begin lo = 9; modelErr = 1'b1; end
      modelVal = hi * 10 + lo;
    end else if (e) begin
      if (d) begin
`ifdef UDB_SATURATE_EN
        if (modelVal != TopVal) modelVal++;
`else
        if (modelVal == TopVal) begin modelVal = 0; modelWrap = 1'b1; end
        else modelVal++;
`endif
      end else begin
`ifdef UDB_SATURATE_EN
        if (modelVal != 0) modelVal--;
`else
        if (modelVal == 0) begin modelVal = TopVal; modelWrap = 1'b1; end
        else modelVal--;
`endif
      end
    end
  endtask

  task automatic checkAll(string tag);
    checkEq({tag, " count"}, 32'(count), 32'(toBcd(modelVal)));
    checkEq({tag, " wrap"}, 32'(wrap), 32'(modelWrap));
    checkEq({tag, " load_err"}, 32'(loadErr), 32'(modelErr));
  endtask

  task automatic cycle(bit ld, bit e, bit d, logic [7:0] lv, string tag);
    load      = ld;
    en        = e;
    dir       = d;
    loadValue = lv;
    @(posedge clk);
    modelStep(ld, e, d, lv);
    #1;
    checkAll(tag);
  endtask

  // Assert reset between edges and check the outputs clear before the next edge
  task automatic asyncReset(string tag);
    #2;
    rst = 1'b1;
    #1;
    modelVal  = 0;
    modelWrap = 1'b0;
    modelErr  = 1'b0;
    checkAll(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    dir       = 1'b0;
    loadValue = '0;
    #3;
    checkAll("reset");
    #9;
    rst = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 8'h47, "load47");
    cycle(1'b0, 1'b1, 1'b1, 8'h00, "up48");
    asyncReset("midcount_rst");
    cycle(1'b0, 1'b1, 1'b1, 8'h00, "after_rst_up");

    cycle(1'b1, 1'b0, 1'b0, 8'h98, "load98");
    cycle(1'b0, 1'b1, 1'b1, 8'h00, "up99");
    cycle(1'b0, 1'b1, 1'b1, 8'h00, "up_wrap");
    cycle(1'b0, 1'b0, 1'b1, 8'h00, "wrap_clears");

    cycle(1'b1, 1'b0, 1'b0, 8'h00, "load00");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "down_wrap");
    cycle(1'b1, 1'b0, 1'b0, 8'h10, "load10");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "down_borrow");

    cycle(1'b1, 1'b0, 1'b0, 8'h3C, "load_clamp");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "hold");
    cycle(1'b1, 1'b0, 1'b0, 8'hFA, "load_clamp_both");

    cycle(1'b1, 1'b1, 1'b1, 8'h25, "load_wins");

    cycle(1'b1, 1'b0, 1'b0, 8'h99, "load99");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'h00, "top_up");
    cycle(1'b1, 1'b0, 1'b0, 8'h00, "load00b");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "bottom_down");

    for (int i = 0; i < 600; i++) begin
      logic [7:0] lv;
      bit         ld;
      lv = 8'($urandom);
      ld = ($urandom_range(0, 7) == 0);
      // bias some loads to the endpoints so wrap/saturation are exercised often
      if (ld && $urandom_range(0, 2) == 0) lv = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
      cycle(ld, ($urandom_range(0, 3) != 0), 1'($urandom), lv, "random");
      if ($urandom_range(0, 99) == 0) asyncReset("random_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
